// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding and instruction opcodes.
//   seq_state_t - 3-bit state of the fetch/decode/memory/writeback sequencer.
//   Opc*        - opcode values consumed by the instruction decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalted = 3'd5
    } seq_state_t;

    localparam logic [3:0] OpcAdd  = 4'h0;
    localparam logic [3:0] OpcSub  = 4'h1;
    localparam logic [3:0] OpcAnd  = 4'h2;
    localparam logic [3:0] OpcOr   = 4'h3;
    localparam logic [3:0] OpcLd   = 4'h8;
    localparam logic [3:0] OpcSt   = 4'h9;
    localparam logic [3:0] OpcHalt = 4'hF;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: IDLE -> FETCH -> DECODE -> (MEM) -> WB -> FETCH,
// with a terminal HALTED state left only by reset. Counts retired instructions.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - level, leaves IDLE
//   imem_ack, dmem_ack  - memory handshakes, honoured only in FETCH / MEM
//   reg_write, mem_read, mem_write, halt - decoded flags of the instruction in IR
//   imem_req, ir_load   - fetch request and IR load strobe
//   dmem_req, dmem_we   - data access request and write qualifier
//   rf_we, pc_en        - writeback strobes, active only in WB
//   halted              - core stopped
//   state_o             - current state encoding
//   retired_cnt         - wrapping 16-bit retired instruction count
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        halt,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_en,
    output logic        halted,
    output logic [2:0]  state_o,
    output logic [15:0] retired_cnt
);

    seq_state_t  state_q, state_d;
    logic [15:0] retired_cnt_q, retired_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            retired_cnt_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Outputs depend only on state plus same-cycle inputs, so reset drops every
    // request immediately together with the state.
    always_comb begin
        state_d       = state_q;
        retired_cnt_d = retired_cnt_q;
        imem_req      = 1'b0;
        ir_load       = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        rf_we         = 1'b0;
        pc_en         = 1'b0;
        halted        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (halt) begin
                    state_d = StHalted;
                end else if (mem_read || mem_write) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                // Read and write together resolve to a write.
                dmem_we  = mem_write;
                if (dmem_ack) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                rf_we         = reg_write;
                pc_en         = 1'b1;
                retired_cnt_d = retired_cnt_q + 16'd1;
                state_d       = StFetch;
            end
            StHalted: begin
                halted = 1'b1;
            end
            default: begin
                // Unused encodings recover to IDLE.
                state_d = StIdle;
            end
        endcase
    end

    assign state_o     = state_q;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer. Inputs change just after the
// falling edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_ack;
    logic        dmem_ack;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        pc_en;
    logic        halted;
    logic [2:0]  state_o;
    logic [15:0] retired_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // State encodings, written out independently of the package.
    localparam logic [2:0] EIdle   = 3'd0;
    localparam logic [2:0] EFetch  = 3'd1;
    localparam logic [2:0] EDecode = 3'd2;
    localparam logic [2:0] EMem    = 3'd3;
    localparam logic [2:0] EWb     = 3'd4;
    localparam logic [2:0] EHalted = 3'd5;

    // Strobes packed as {imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, halted}.
    localparam logic [6:0] SNone     = 7'b0000000;
    localparam logic [6:0] SFetch    = 7'b1000000;
    localparam logic [6:0] SFetchAck = 7'b1100000;
    localparam logic [6:0] SMemRd    = 7'b0010000;
    localparam logic [6:0] SMemWr    = 7'b0011000;
    localparam logic [6:0] SWbReg    = 7'b0000110;
    localparam logic [6:0] SWbNoReg  = 7'b0000010;
    localparam logic [6:0] SHalt     = 7'b0000001;

    cpu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_ack    (imem_ack),
        .dmem_ack    (dmem_ack),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .halt        (halt),
        .imem_req    (imem_req),
        .ir_load     (ir_load),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .rf_we       (rf_we),
        .pc_en       (pc_en),
        .halted      (halted),
        .state_o     (state_o),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [6:0] strb);
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_strobes"},
              32'({imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_en, halted}), 32'(strb));
        // Structural invariants hold in every sampled cycle.
        check({tag, "_req_excl"}, 32'(imem_req & dmem_req), 32'd0);
    endtask

    task automatic next_cycle;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        imem_ack  = 1'b0;
        dmem_ack  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halt      = 1'b0;

        // Reset state
        next_cycle();
        #1;
        expect_cyc("reset", EIdle, SNone);
        check("reset_cnt", 32'(retired_cnt), 32'd0);

        // IDLE ignores acks and waits for start
        next_cycle();
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        #1;
        expect_cyc("idle0", EIdle, SNone);
        next_cycle();
        #1;
        expect_cyc("idle1", EIdle, SNone);
        start    = 1'b1;
        dmem_ack = 1'b0;

        // ADD with immediate ack: FETCH, DECODE, WB
        next_cycle();
        start     = 1'b0;
        reg_write = 1'b1;
        #1;
        expect_cyc("add_c1", EFetch, SFetchAck);
        next_cycle();
        #1;
        expect_cyc("add_c2", EDecode, SNone);
        next_cycle();
        #1;
        expect_cyc("add_c3", EWb, SWbReg);
        check("add_cnt_in_wb", 32'(retired_cnt), 32'd0);
        next_cycle();
        imem_ack = 1'b0;
        mem_read = 1'b1;
        #1;
        check("add_cnt", 32'(retired_cnt), 32'd1);

        // LD: one fetch wait, then dmem_ack after two wait cycles
        expect_cyc("ld_fwait", EFetch, SFetch);
        next_cycle();
        imem_ack = 1'b1;
        #1;
        expect_cyc("ld_c1", EFetch, SFetchAck);
        next_cycle();
        dmem_ack = 1'b1;
        #1;
        expect_cyc("ld_c2", EDecode, SNone);
        next_cycle();
        dmem_ack = 1'b0;
        #1;
        expect_cyc("ld_c3", EMem, SMemRd);
        next_cycle();
        #1;
        expect_cyc("ld_c4", EMem, SMemRd);
        next_cycle();
        dmem_ack = 1'b1;
        #1;
        expect_cyc("ld_c5", EMem, SMemRd);
        next_cycle();
        dmem_ack = 1'b0;
        #1;
        expect_cyc("ld_c6", EWb, SWbReg);
        next_cycle();
        #1;
        check("ld_cnt", 32'(retired_cnt), 32'd2);

        // ST with read and write both set: treated as write, no register write
        mem_write = 1'b1;
        reg_write = 1'b0;
        #1;
        expect_cyc("st_c1", EFetch, SFetchAck);
        next_cycle();
        #1;
        expect_cyc("st_c2", EDecode, SNone);
        next_cycle();
        dmem_ack = 1'b1;
        #1;
        expect_cyc("st_c3", EMem, SMemWr);
        next_cycle();
        dmem_ack = 1'b0;
        #1;
        expect_cyc("st_c4", EWb, SWbNoReg);
        next_cycle();
        #1;
        check("st_cnt", 32'(retired_cnt), 32'd3);

        // Counter wrap: preset the count near the top while the fetch stalls
        imem_ack  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b1;
        force dut.retired_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.retired_cnt_q;
        next_cycle();
        #1;
        check("wrap_preset", 32'(retired_cnt), 32'hFFFE);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            next_cycle();
            next_cycle();
            #1;
            expect_cyc($sformatf("wrap_fetch%0d", i), EFetch, SFetchAck);
            check($sformatf("wrap_cnt%0d", i), 32'(retired_cnt),
                  (i == 0) ? 32'hFFFF : (i == 1) ? 32'h0000 : 32'h0001);
        end

        // HALT has priority over the memory flags; stays halted while start toggles
        halt     = 1'b1;
        mem_read = 1'b1;
        #1;
        expect_cyc("halt_c1", EFetch, SFetchAck);
        next_cycle();
        #1;
        expect_cyc("halt_c2", EDecode, SNone);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            start    = i[0];
            dmem_ack = i[1];
            #1;
            expect_cyc($sformatf("halted%0d", i), EHalted, SHalt);
            check($sformatf("halted_cnt%0d", i), 32'(retired_cnt), 32'd1);
        end

        // Reset leaves HALTED
        rst_n = 1'b0;
        #1;
        expect_cyc("halt_reset", EIdle, SNone);
        check("halt_reset_cnt", 32'(retired_cnt), 32'd0);

        // One ADD, then a load stalled in MEM that is cut by reset
        next_cycle();
        rst_n    = 1'b1;
        start    = 1'b1;
        halt     = 1'b0;
        mem_read = 1'b0;
        dmem_ack = 1'b0;
        imem_ack = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        mem_read = 1'b1;
        #1;
        check("rm_cnt_pre", 32'(retired_cnt), 32'd1);
        next_cycle();
        next_cycle();
        #1;
        expect_cyc("rm_mem", EMem, SMemRd);
        #2;
        rst_n = 1'b0;
        #1;
        expect_cyc("rm_reset", EIdle, SNone);
        check("rm_cnt", 32'(retired_cnt), 32'd0);
        next_cycle();
        rst_n    = 1'b1;
        dmem_ack = 1'b1;
        #1;
        expect_cyc("rm_after0", EIdle, SNone);
        next_cycle();
        #1;
        expect_cyc("rm_after1", EIdle, SNone);
        check("rm_after_cnt", 32'(retired_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
